// File: rtl/mfcc_melbank_filter_pkg.sv
// Shared constants and FSM encoding for the mel-filterbank reader.
package mfcc_melbank_filter_pkg;
  localparam int MFCC_N_BINS    = 512;
  localparam int MFCC_COEF_FRAC = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/mfcc_melbank_filter_mac_sat.sv
// Registered unsigned multiply followed by a saturating accumulator with
// per-tag load and a sticky overflow flag; a small tag rides along with the data.
module mfcc_mac_sat #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 48,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic              in_load,
  input  logic [DATA_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_vld,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic [TAG_W-1:0]  out_tag
);
  localparam int PROD_W = DATA_W + COEF_W;

  // Returns {saturated, value}; load restarts the sum from zero.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  acc,
                                             input logic [PROD_W-1:0] prod,
                                             input logic              load);
    logic [ACC_W:0] sum;
    sum = (load ? '0 : {1'b0, acc}) + (ACC_W+1)'(prod);
    if (sum[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return sum;
  endfunction

  logic              vld_p1, vld_p2;
  logic [PROD_W-1:0] prod_p1;
  logic              load_p1;
  logic [TAG_W-1:0]  tag_p1, tag_p2;
  logic [ACC_W-1:0]  acc_p2;
  logic              ovf_p2;
  logic [ACC_W:0]    sum_p1;

  always_comb sum_p1 = sat_add(acc_p2, prod_p1, load_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ovf_p2 <= 1'b0;
    end else begin
      vld_p1 <= in_vld;
      vld_p2 <= vld_p1;
      if (vld_p1) ovf_p2 <= sum_p1[ACC_W] | (~load_p1 & ovf_p2);
    end
  end

  // S1: product register; S2: accumulator
  always_ff @(posedge clk) begin
    if (in_vld) begin
      prod_p1 <= PROD_W'(a) * PROD_W'(b);
      load_p1 <= in_load;
      tag_p1  <= in_tag;
    end
    if (vld_p1) begin
      acc_p2 <= sum_p1[ACC_W-1:0];
      tag_p2 <= tag_p1;
    end
  end

  assign out_vld = vld_p2;
  assign out_acc = acc_p2;
  assign out_ovf = ovf_p2;
  assign out_tag = tag_p2;
endmodule

// File: rtl/mfcc_melbank_filter.sv
// One mel band: walks the coefficient ROM with the bin index, weights each
// power bin and emits the per-frame weighted sum with overflow/length flags.
module mfcc_melbank_filter
  import mfcc_melbank_filter_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int COEF_WIDTH = MFCC_COEF_FRAC,
  parameter int PWR_WIDTH  = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int N_BINS     = MFCC_N_BINS,
  parameter int ROM_LAT    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwr_valid,
  input  logic [PWR_WIDTH-1:0]  pwr_data,
  input  logic                  pwr_last,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COEF_WIDTH-1:0] rom_data,
  output logic                  mel_valid,
  output logic [ACC_WIDTH-1:0]  mel_data,
  output logic                  mel_ovf,
  output logic                  frame_err
);
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(N_BINS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] bin_cnt, cnt_d;
  logic                  at_last_bin, first_beat, end_beat, len_err;

  // A frame ends on pwr_last or on the final bin, whichever comes first;
  // a length error is any disagreement between the two.
  always_comb begin
    state_d     = state_q;
    cnt_d       = bin_cnt;
    at_last_bin = (bin_cnt == LAST_BIN);
    first_beat  = 1'b0;
    end_beat    = 1'b0;
    len_err     = pwr_last ^ at_last_bin;
    if (pwr_valid) begin
      first_beat = (state_q == IDLE);
      end_beat   = pwr_last | at_last_bin;
      if (end_beat) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = RUN;
        cnt_d   = bin_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_cnt <= '0;
    end else begin
      state_q <= state_d;
      bin_cnt <= cnt_d;
    end
  end

  assign rom_addr = bin_cnt;

  logic                 vld_p0, first_p0, end_p0, err_p0;
  logic [PWR_WIDTH-1:0] pwr_p0;

  // P0: align the beat with the ROM read data
  generate
    if (ROM_LAT == 0) begin : g_lat0
      assign vld_p0   = pwr_valid;
      assign pwr_p0   = pwr_data;
      assign first_p0 = first_beat;
      assign end_p0   = end_beat;
      assign err_p0   = len_err;
    end else begin : g_lat1
      logic vld_r;
      logic [PWR_WIDTH-1:0] pwr_r;
      logic first_r, end_r, err_r;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_r <= 1'b0;
        else        vld_r <= pwr_valid;
      end
      always_ff @(posedge clk) begin
        if (pwr_valid) begin
          pwr_r   <= pwr_data;
          first_r <= first_beat;
          end_r   <= end_beat;
          err_r   <= len_err;
        end
      end
      assign vld_p0   = vld_r;
      assign pwr_p0   = pwr_r;
      assign first_p0 = first_r;
      assign end_p0   = end_r;
      assign err_p0   = err_r;
    end
  endgenerate

  logic                 vld_p2, ovf_p2;
  logic [ACC_WIDTH-1:0] acc_p2;
  logic [1:0]           tag_p2;

  mfcc_mac_sat #(
    .DATA_W (PWR_WIDTH),
    .COEF_W (COEF_WIDTH),
    .ACC_W  (ACC_WIDTH),
    .TAG_W  (2)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (vld_p0),
    .in_load (first_p0),
    .a       (pwr_p0),
    .b       (rom_data),
    .in_tag  ({end_p0, err_p0}),
    .out_vld (vld_p2),
    .out_acc (acc_p2),
    .out_ovf (ovf_p2),
    .out_tag (tag_p2)
  );

  // P3: result registers hold until the next frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mel_valid <= 1'b0;
      mel_data  <= '0;
      mel_ovf   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mel_valid <= vld_p2 & tag_p2[1];
      if (vld_p2 & tag_p2[1]) begin
        mel_data  <= acc_p2;
        mel_ovf   <= ovf_p2;
        frame_err <= tag_p2[0];
      end
    end
  end
endmodule

// File: tb/tb_mfcc_melbank_filter.sv
// Directed bench: four instances (ROM_LAT 0/1 x ACC_WIDTH 48/40) share one spectrum stream.
module tb_mfcc_melbank_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwr_valid = 1'b0;
  logic        pwr_last = 1'b0;
  logic [31:0] pwr_data = '0;

  always #5 clk = ~clk;

  logic [7:0] rom [512];
  wire  [8:0] ra0, ra1, ra2, ra3;
  logic [7:0] rd0, rd1, rd2, rd3;
  wire        mv0, mv1, mv2, mv3, mo0, mo1, mo2, mo3, me0, me1, me2, me3;
  wire [47:0] md0, md1;
  wire [39:0] md2, md3;

  assign rd0 = rom[ra0];
  assign rd2 = rom[ra2];
  always @(posedge clk) rd1 <= rom[ra1];
  always @(posedge clk) rd3 <= rom[ra3];

  mfcc_melbank_filter #(.ACC_WIDTH(48), .ROM_LAT(0)) u0 (.clk(clk), .rst_n(rst_n),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last), .rom_addr(ra0),
    .rom_data(rd0), .mel_valid(mv0), .mel_data(md0), .mel_ovf(mo0), .frame_err(me0));
  mfcc_melbank_filter #(.ACC_WIDTH(48), .ROM_LAT(1)) u1 (.clk(clk), .rst_n(rst_n),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last), .rom_addr(ra1),
    .rom_data(rd1), .mel_valid(mv1), .mel_data(md1), .mel_ovf(mo1), .frame_err(me1));
  mfcc_melbank_filter #(.ACC_WIDTH(40), .ROM_LAT(0)) u2 (.clk(clk), .rst_n(rst_n),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last), .rom_addr(ra2),
    .rom_data(rd2), .mel_valid(mv2), .mel_data(md2), .mel_ovf(mo2), .frame_err(me2));
  mfcc_melbank_filter #(.ACC_WIDTH(40), .ROM_LAT(1)) u3 (.clk(clk), .rst_n(rst_n),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last), .rom_addr(ra3),
    .rom_data(rd3), .mel_valid(mv3), .mel_data(md3), .mel_ovf(mo3), .frame_err(me3));

  typedef struct {
    logic        mv;
    logic [47:0] md;
    logic        mo;
    logic        me;
    logic [8:0]  ra;
  } out_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic [47:0] data;
    logic        ovf;
    logic        err;
  } pulse_t;

  typedef struct {
    int          rom_mode;
    int          pmode;
    int          n;
    int          last_at;
    int          gap;
    logic [47:0] exp;
    logic        sat;
    logic        err;
  } rec_t;

  function automatic out_t cur(input int i);
    out_t o;
    case (i)
      0:       o = '{mv0, md0, mo0, me0, ra0};
      1:       o = '{mv1, md1, mo1, me1, ra1};
      2:       o = '{mv2, {8'h00, md2}, mo2, me2, ra2};
      default: o = '{mv3, {8'h00, md3}, mo3, me3, ra3};
    endcase
    return o;
  endfunction

  function automatic int lat(input int i);
    return i % 2;
  endfunction

  function automatic logic [47:0] exp_data(input int i, input rec_t r);
    if (!r.sat) return r.exp;
    return (i < 2) ? 48'hFFFF_FFFF_FFFF : 48'h00FF_FFFF_FFFF;
  endfunction

  function automatic logic [31:0] pval(input int m, input int k);
    case (m)
      0:       return 32'd100;
      1:       return 32'(k);
      2:       return 32'hFFFF_FFFF;
      default: return 32'd1;
    endcase
  endfunction

  int     cyc = 0;
  pulse_t pq[$];
  out_t   mon_o;
  int     n_chk = 0;
  int     n_pass = 0;
  int     addr_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      mon_o = cur(i);
      if (mon_o.mv === 1'b1) pq.push_back('{i, cyc, mon_o.md, mon_o.mo, mon_o.me});
    end
  end

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[u%0d]: got %0d expected %0d", nm, inst, act, exp);
  endtask

  task automatic set_rom(input int mode);
    for (int j = 0; j < 512; j++) rom[j] = (mode == 0) ? 8'h80 : (mode == 2) ? 8'hFF : 8'h00;
    if (mode == 1) begin
      rom[10] = 8'h40;
      rom[11] = 8'hFF;
      rom[12] = 8'h40;
    end
  endtask

  task automatic chk_addr(input int bin);
    for (int i = 0; i < 4; i++) begin
      mon_o = cur(i);
      if (mon_o.ra !== 9'(bin)) addr_err++;
    end
  endtask

  task automatic drive(input int pmode, input int n, input int last_at, input int gap, output int e_cyc);
    int bin;
    bin   = 0;
    e_cyc = -1;
    for (int k = 0; k < n; k++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        pwr_valid = 1'b0;
        pwr_last  = 1'b0;
        chk_addr(bin);
        @(posedge clk); #1;
      end
      chk_addr(bin);
      pwr_valid = 1'b1;
      pwr_data  = pval(pmode, k);
      pwr_last  = (k == last_at);
      @(posedge clk); #1;
      if (k == last_at || bin == 511) begin
        e_cyc = cyc;
        bin   = 0;
      end else begin
        bin++;
      end
    end
    pwr_valid = 1'b0;
    pwr_last  = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1;
  endtask

  function automatic int count_pulses(input int i);
    int c = 0;
    foreach (pq[j]) if (pq[j].inst == i) c++;
    return c;
  endfunction

  task automatic expect_pulse(input int i, input int nth, input int ecyc,
                              input logic [47:0] ed, input logic eo, input logic ee);
    int seen = 0;
    foreach (pq[j]) begin
      if (pq[j].inst == i) begin
        if (seen == nth) begin
          chk("pulse_cycle", i, pq[j].cyc, ecyc);
          chk("mel_data", i, pq[j].data, ed);
          chk("mel_ovf", i, pq[j].ovf, eo);
          chk("frame_err", i, pq[j].err, ee);
        end
        seen++;
      end
    end
  endtask

  task automatic chk_reset_state(input string nm);
    for (int i = 0; i < 4; i++) begin
      mon_o = cur(i);
      chk({nm, "_outs"}, i, {mon_o.mv, mon_o.mo, mon_o.me}, 3'b000);
      chk({nm, "_data"}, i, mon_o.md, 0);
      chk({nm, "_addr"}, i, mon_o.ra, 0);
    end
  endtask

  rec_t tbl[8];
  int   e, ea, eb;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 0, 512, 511, 0, 48'd6553600, 1'b0, 1'b0};  // nominal frame
    tbl[1] = '{1, 1, 512, 511, 0, 48'd4213,    1'b0, 1'b0};  // sparse ROM
    tbl[2] = '{0, 0, 512, 511, 30, 48'd6553600, 1'b0, 1'b0}; // valid gaps
    tbl[3] = '{2, 2, 512, 511, 0, 48'd0,       1'b1, 1'b0};  // saturation
    tbl[4] = '{0, 0, 512, 511, 0, 48'd6553600, 1'b0, 1'b0};  // ovf clears
    tbl[5] = '{0, 0, 100, 99,  0, 48'd1280000, 1'b0, 1'b1};  // early end
    tbl[6] = '{0, 0, 512, -1,  0, 48'd6553600, 1'b0, 1'b1};  // implicit end
    tbl[7] = '{0, 0, 512, 511, 0, 48'd6553600, 1'b0, 1'b0};  // clean after implicit
    set_rom(0);

    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[t]) begin
      set_rom(tbl[t].rom_mode);
      pq.delete();
      addr_err = 0;
      drive(tbl[t].pmode, tbl[t].n, tbl[t].last_at, tbl[t].gap, e);
      drain();
      chk("addr_sweep", t, addr_err, 0);
      for (int i = 0; i < 4; i++) begin
        chk("n_pulses", i, count_pulses(i), 1);
        expect_pulse(i, 0, e + lat(i) + 2, exp_data(i, tbl[t]), tbl[t].sat, tbl[t].err);
        mon_o = cur(i);
        chk("hold_data", i, mon_o.md, exp_data(i, tbl[t]));
      end
    end

    // Back-to-back frames with no idle cycle between them
    set_rom(0);
    pq.delete();
    drive(0, 512, 511, 0, ea);
    drive(3, 512, 511, 0, eb);
    drain();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_n_pulses", i, count_pulses(i), 2);
      expect_pulse(i, 0, ea + lat(i) + 2, 48'd6553600, 1'b0, 1'b0);
      expect_pulse(i, 1, eb + lat(i) + 2, 48'd65536, 1'b0, 1'b0);
    end

    // Early-ended frame, then reset in the middle of the next one
    pq.delete();
    drive(0, 100, 99, 0, e);
    drain();
    for (int i = 0; i < 4; i++) expect_pulse(i, 0, e + lat(i) + 2, 48'd1280000, 1'b0, 1'b1);
    pq.delete();
    drive(0, 200, -1, 0, e);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("midreset");
    rst_n = 1'b1;
    drain();
    chk("no_pulse_after_reset", -1, pq.size(), 0);
    pq.delete();
    addr_err = 0;
    drive(0, 512, 511, 0, e);
    drain();
    chk("addr_after_reset", -1, addr_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk("post_reset_n_pulses", i, count_pulses(i), 1);
      expect_pulse(i, 0, e + lat(i) + 2, 48'd6553600, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
